vector_collector: RTL

- Receive end of the 4-lane serial row-mask link.
- Captures the four 1-bit lanes (data_in1..data_in4) over 4 beats and rebuilds the 16-bit active-row mask.
- Reports the mask and its population count.
- Hands out the index of each active row, lowest first, over a valid/ready handshake, so the downstream lower-triangular stage can process rows one at a time.

---
 rtl/vector_collector.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/vector_collector.sv
// vector_collector
//   Receive end of the 4-lane serial row-mask link. Four 1-bit lanes are
//   captured over four beats and rebuilt into a 16-bit active-row mask. The
//   mask and its population count are reported, then the index of every set
//   bit is handed out, lowest first, over a valid/ready handshake.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for rx_enable (only after it has been seen low)
//   CAPTURE | sampling beats 1..3 of the current frame
//   ISSUE   | presenting lowest remaining row on row_index/row_valid
//   DONE    | all rows issued (or empty mask); done pulses on the next cycle
//
// Ports
//   clock, reset_n        system clock, async active-low reset
//   rx_enable             beat qualifier from the transmitter
//   data_in1..data_in4    lanes 0..3
//   row_ready             downstream accepts the current row_index
//   abort                 synchronous flush back to IDLE
//   mask, mask_valid      captured mask and its one-cycle completion pulse
//   active_count          popcount of mask
//   row_valid, row_index  current row handshake
//   row_last              current row is the final remaining one
//   busy, done            not IDLE / all rows issued pulse

module vector_collector #(
    parameter int LANES = 4,
    parameter int BEATS = 4,
    parameter int IDX_W = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       rx_enable,
    input  logic                       data_in1,
    input  logic                       data_in2,
    input  logic                       data_in3,
    input  logic                       data_in4,
    input  logic                       row_ready,
    input  logic                       abort,
    output logic [LANES*BEATS-1:0]     mask,
    output logic                       mask_valid,
    output logic [$clog2(LANES*BEATS+1)-1:0] active_count,
    output logic                       row_valid,
    output logic [IDX_W-1:0]           row_index,
    output logic                       row_last,
    output logic                       busy,
    output logic                       done
);

    localparam int MASK_W = LANES * BEATS;
    localparam int CNT_W  = $clog2(MASK_W + 1);
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ISSUE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q;
    logic [MASK_W-1:0]   cap_q;
    logic [MASK_W-1:0]   mask_q;
    logic [MASK_W-1:0]   remaining_q;
    logic [CNT_W-1:0]    count_q;
    logic                mask_valid_q;
    logic                done_q;
    logic                seen_low_q;

    logic [LANES-1:0]    lanes;
    logic [MASK_W-1:0]   asm_mask;
    logic [IDX_W-1:0]    low_idx;
    logic                one_left;
    logic                capture_start;
    logic                sample;
    logic                frame_end;
    logic                frame_drop;
    logic                accept;

    function automatic logic [CNT_W-1:0] popcount(input logic [MASK_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < MASK_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    assign lanes = {data_in4, data_in3, data_in2, data_in1};

    // Frame as it would look if the current lanes were written at beat_q.
    always_comb begin
        asm_mask = cap_q;
        asm_mask[beat_q*LANES +: LANES] = lanes;
    end

    // Descending scan so the lowest set bit is the one left standing.
    always_comb begin
        low_idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (remaining_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign one_left = (remaining_q != '0) &&
                      ((remaining_q & (remaining_q - MASK_W'(1))) == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        capture_start = 1'b0;
        sample        = 1'b0;
        frame_end     = 1'b0;
        frame_drop    = 1'b0;
        accept        = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_enable && seen_low_q) begin
                    capture_start = 1'b1;
                    state_d       = CAPTURE;
                end
            end
            CAPTURE: begin
                if (rx_enable) begin
                    sample = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        frame_end = 1'b1;
                        state_d   = (asm_mask != '0) ? ISSUE : DONE;
                    end
                end else begin
                    frame_drop = 1'b1;
                    state_d    = IDLE;
                end
            end
            ISSUE: begin
                if (row_ready) begin
                    accept = 1'b1;
                    if (one_left) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort) begin
            state_d       = IDLE;
            capture_start = 1'b0;
            sample        = 1'b0;
            frame_end     = 1'b0;
            frame_drop    = 1'b0;
            accept        = 1'b0;
        end
    end

    // seen_low_q comes out of reset set: rx_enable is low while reset is held,
    // so the first frame after reset is accepted immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beat_q       <= '0;
            cap_q        <= '0;
            mask_q       <= '0;
            remaining_q  <= '0;
            count_q      <= '0;
            mask_valid_q <= 1'b0;
            done_q       <= 1'b0;
            seen_low_q   <= 1'b1;
        end else begin
            mask_valid_q <= frame_end;
            done_q       <= (state_q == DONE) && !abort;
            seen_low_q   <= capture_start ? 1'b0 : (seen_low_q | ~rx_enable);
            if (abort) begin
                beat_q      <= '0;
                remaining_q <= '0;
            end else begin
                if (capture_start) begin
                    cap_q[LANES-1:0] <= lanes;
                    beat_q           <= BEAT_W'(1);
                end
                if (sample) begin
                    cap_q <= asm_mask;
                    if (!frame_end) begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                if (frame_drop || state_q == DONE) begin
                    beat_q <= '0;
                end
                if (frame_end) begin
                    mask_q      <= asm_mask;
                    remaining_q <= asm_mask;
                    count_q     <= popcount(asm_mask);
                end
                if (accept) begin
                    remaining_q <= remaining_q & ~(MASK_W'(1) << low_idx);
                end
            end
        end
    end

    assign mask         = mask_q;
    assign mask_valid   = mask_valid_q;
    assign active_count = count_q;
    assign row_valid    = (state_q == ISSUE);
    assign row_index    = low_idx;
    assign row_last     = row_valid && one_left;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

endmodule
